// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32IM inter-stage registers: stage-state
// encoding, control-field bit positions and per-stage NOP control words.
package rv_pipe_pkg;

   // Occupancy-coded state: the encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

   // Control-field bit positions within the 16-bit control payload.
   localparam int CTRL_ALU_SRC    = 0;
   localparam int CTRL_ALU_OP_LSB = 1;
   localparam int CTRL_ALU_OP_MSB = 4;
   localparam int CTRL_MEM_RD     = 5;
   localparam int CTRL_MEM_WR     = 6;
   localparam int CTRL_REG_WRITE  = 7;
   localparam int CTRL_MEM_TO_REG = 8;
   localparam int CTRL_BRANCH     = 9;
   localparam int CTRL_JUMP       = 10;

   // NOP control words per stage boundary; none may write memory or the register file.
   localparam logic [15:0] NOP_CTRL_IDEX  = 16'h0000;
   localparam logic [15:0] NOP_CTRL_EXMEM = 16'h0000;
   localparam logic [15:0] NOP_CTRL_MEMWB = 16'h0000;

   // True when a control word has no architectural side effect.
   function automatic logic ctrl_is_safe_nop(input logic [15:0] ctrl);
      return !ctrl[CTRL_REG_WRITE] && !ctrl[CTRL_MEM_WR];
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: valid + data + control, with
// load, clear and a NOP mask that substitutes the bubble control word.
module pipe_slot
   import rv_pipe_pkg::*;
#(
   parameter int                DATA_W   = 128,
   parameter int                CTRL_W   = 16,
   parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic              nop_mask,
   input  logic              d_valid,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              q_valid,
   output logic [DATA_W-1:0] q_data,
   output logic [CTRL_W-1:0] q_ctrl
);

   // Clear wins over load; clearing leaves the data bits untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_valid <= 1'b0;
         q_data  <= '0;
         q_ctrl  <= NOP_CTRL;
      end else if (clear) begin
         q_valid <= 1'b0;
         q_ctrl  <= NOP_CTRL;
      end else if (load) begin
         q_valid <= d_valid;
         q_data  <= d_data;
         q_ctrl  <= nop_mask ? NOP_CTRL : d_ctrl;
      end
   end

endmodule

// File: rtl/pipeline_stage_reg.sv
// Generic valid/ready inter-stage register with stall, flush and bubble
// injection. SKID=1 adds a second slot so in_ready_o comes from a flop.
module pipeline_stage_reg
   import rv_pipe_pkg::*;
#(
   parameter int                DATA_W   = 128,
   parameter int                CTRL_W   = 16,
   parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
   parameter int                SKID     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              bubble_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [1:0]        occupancy_o
);

   stage_state_e      state, state_nxt;
   logic              in_xfer, out_xfer;
   logic              main_ld, main_clr, main_from_skid;
   logic              skid_ld, skid_clr;
   logic              main_valid, skid_valid;
   logic [DATA_W-1:0] main_data, skid_data;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

   // A flushed cycle never accepts its input, even if ready is high.
   assign in_xfer  = in_valid_i & in_ready_o & ~flush_i;
   assign out_xfer = main_valid & out_ready_i;

   // Next state and slot load/clear strobes; flush overrides the handshake.
   always_comb begin
      state_nxt      = state;
      main_ld        = 1'b0;
      main_clr       = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      skid_clr       = 1'b0;
      if (flush_i) begin
         state_nxt = ST_EMPTY;
         main_clr  = 1'b1;
         skid_clr  = 1'b1;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_xfer) begin
                  main_ld   = 1'b1;
                  state_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_ld = 1'b1;
               end else if (in_xfer) begin
                  skid_ld   = 1'b1;
                  state_nxt = ST_TWO;
               end else if (out_xfer) begin
                  main_clr  = 1'b1;
                  state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_xfer) begin
                  main_ld        = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
                  state_nxt      = ST_ONE;
               end
            end
            default: begin
               state_nxt = ST_EMPTY;
               main_clr  = 1'b1;
               skid_clr  = 1'b1;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_EMPTY;
      else     state <= state_nxt;
   end

   // Head slot: fed from the input, or from the skid slot when draining TWO.
   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_CTRL(NOP_CTRL)) u_main (
      .clk      (clk),
      .rst      (rst),
      .load     (main_ld),
      .clear    (main_clr),
      .nop_mask (bubble_i & ~main_from_skid),
      .d_valid  (main_from_skid ? skid_valid : 1'b1),
      .d_data   (main_from_skid ? skid_data  : in_data_i),
      .d_ctrl   (main_from_skid ? skid_ctrl  : in_ctrl_i),
      .q_valid  (main_valid),
      .q_data   (main_data),
      .q_ctrl   (main_ctrl)
   );

   if (SKID != 0) begin : g_skid
      logic rdy_q;

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_CTRL(NOP_CTRL)) u_skid (
         .clk      (clk),
         .rst      (rst),
         .load     (skid_ld),
         .clear    (skid_clr),
         .nop_mask (bubble_i),
         .d_valid  (1'b1),
         .d_data   (in_data_i),
         .d_ctrl   (in_ctrl_i),
         .q_valid  (skid_valid),
         .q_data   (skid_data),
         .q_ctrl   (skid_ctrl)
      );

      // Ready is precomputed from the next state so it leaves a flop.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) rdy_q <= 1'b1;
         else     rdy_q <= (state_nxt != ST_TWO);
      end

      assign in_ready_o = rdy_q;
   end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = NOP_CTRL;
      assign in_ready_o = ~main_valid | out_ready_i;
   end

   assign out_valid_o = main_valid;
   assign out_data_o  = main_data;
   assign out_ctrl_o  = main_valid ? main_ctrl : NOP_CTRL;
   assign occupancy_o = state;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: one SKID=1 and one SKID=0 instance share
// the same stimulus; each has its own expected-entry queue.
module tb_pipeline_stage_reg;

   localparam int          DW  = 32;
   localparam int          CW  = 16;
   localparam logic [15:0] NOP = 16'h0013;

   logic          clk = 1'b0;
   logic          rst, flush, bubble, in_valid, out_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;

   logic          rdy1, ov1, rdy0, ov0;
   logic [DW-1:0] od1, od0;
   logic [CW-1:0] oc1, oc0;
   logic [1:0]    occ1, occ0;

   logic [DW+CW-1:0] q1[$];
   logic [DW+CW-1:0] q0[$];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipeline_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .SKID(1)) dut1 (
      .clk(clk), .rst(rst), .flush_i(flush), .bubble_i(bubble),
      .in_valid_i(in_valid), .in_ready_o(rdy1), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
      .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1), .out_ctrl_o(oc1),
      .occupancy_o(occ1)
   );

   pipeline_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .SKID(0)) dut0 (
      .clk(clk), .rst(rst), .flush_i(flush), .bubble_i(bubble),
      .in_valid_i(in_valid), .in_ready_o(rdy0), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
      .out_valid_o(ov0), .out_ready_i(out_ready), .out_data_o(od0), .out_ctrl_o(oc0),
      .occupancy_o(occ0)
   );

   task automatic test_reset;
      tests++; if (ov1 !== 1'b0)  begin fails++; $display("FAIL por_valid1: got %b want 0", ov1); end
      tests++; if (oc1 !== NOP)   begin fails++; $display("FAIL por_ctrl1: got %h want %h", oc1, NOP); end
      tests++; if (occ1 !== 2'd0) begin fails++; $display("FAIL por_occ1: got %0d want 0", occ1); end
      tests++; if (rdy1 !== 1'b1) begin fails++; $display("FAIL por_ready1: got %b want 1", rdy1); end
      tests++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL por_ready0: got %b want 1", rdy0); end
      rst = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h5; in_ctrl = 16'h00F0; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      tests++; if (ov1 !== 1'b1) begin fails++; $display("FAIL pre_rst_valid1: got %b want 1", ov1); end
      #2 rst = 1'b1;
      #1;
      tests++; if (ov1 !== 1'b0)   begin fails++; $display("FAIL rst_valid1: got %b want 0", ov1); end
      tests++; if (oc1 !== NOP)    begin fails++; $display("FAIL rst_ctrl1: got %h want %h", oc1, NOP); end
      tests++; if (od1 !== '0)     begin fails++; $display("FAIL rst_data1: got %h want 0", od1); end
      tests++; if (occ1 !== 2'd0)  begin fails++; $display("FAIL rst_occ1: got %0d want 0", occ1); end
      tests++; if (rdy1 !== 1'b1)  begin fails++; $display("FAIL rst_ready1: got %b want 1", rdy1); end
      tests++; if (ov0 !== 1'b0)   begin fails++; $display("FAIL rst_valid0: got %b want 0", ov0); end
      tests++; if (oc0 !== NOP)    begin fails++; $display("FAIL rst_ctrl0: got %h want %h", oc0, NOP); end
      tests++; if (rdy0 !== 1'b1)  begin fails++; $display("FAIL rst_ready0: got %b want 1", rdy0); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_streaming;
      logic [DW+CW-1:0] exp;
      q1.delete(); q0.delete();
      out_ready = 1'b1; bubble = 1'b0; flush = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         in_valid = (i <= 8);
         in_data  = DW'(i);
         in_ctrl  = 16'h0100 | 16'(i);
         #1;
         if (i >= 2 && i <= 9) begin
            tests++; if (ov1 !== 1'b1 || occ1 !== 2'd1) begin fails++; $display("FAIL stream_occ1 cyc %0d: got v=%b occ=%0d want v=1 occ=1", i, ov1, occ1); end
            tests++; if (ov0 !== 1'b1 || occ0 !== 2'd1) begin fails++; $display("FAIL stream_occ0 cyc %0d: got v=%b occ=%0d want v=1 occ=1", i, ov0, occ0); end
         end
         if (i <= 8) begin
            tests++; if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin fails++; $display("FAIL stream_ready cyc %0d: got %b/%b want 1/1", i, rdy1, rdy0); end
         end
         if (ov1 && out_ready && q1.size() > 0) begin
            exp = q1.pop_front();
            tests++; if ({oc1, od1} !== exp) begin fails++; $display("FAIL stream_data1: got %h want %h", {oc1, od1}, exp); end
         end
         if (ov0 && out_ready && q0.size() > 0) begin
            exp = q0.pop_front();
            tests++; if ({oc0, od0} !== exp) begin fails++; $display("FAIL stream_data0: got %h want %h", {oc0, od0}, exp); end
         end
         if (in_valid && rdy1) q1.push_back({in_ctrl, in_data});
         if (in_valid && rdy0) q0.push_back({in_ctrl, in_data});
         @(negedge clk);
      end
      tests++; if (q1.size() != 0 || q0.size() != 0) begin fails++; $display("FAIL stream_drain: got %0d/%0d left want 0/0", q1.size(), q0.size()); end
   endtask

   task automatic test_backpressure;
      logic [DW-1:0] offers [3];
      logic [DW-1:0] got[$];
      int idx = 0;
      offers[0] = 32'hA; offers[1] = 32'hB; offers[2] = 32'hC;
      in_ctrl = 16'h0004;
      for (int cyc = 0; cyc < 10; cyc++) begin
         out_ready = (cyc >= 4);
         in_valid  = (idx < 3);
         in_data   = (idx < 3) ? offers[idx] : '0;
         #1;
         if (cyc == 3) begin
            tests++; if (occ1 !== 2'd2)   begin fails++; $display("FAIL bp_occ: got %0d want 2", occ1); end
            tests++; if (rdy1 !== 1'b0)   begin fails++; $display("FAIL bp_ready: got %b want 0", rdy1); end
            tests++; if (od1 !== 32'hA)   begin fails++; $display("FAIL bp_head: got %h want a", od1); end
            tests++; if (idx != 2)        begin fails++; $display("FAIL bp_c_waits: got %0d accepted want 2", idx); end
         end
         if (ov1 && out_ready) got.push_back(od1);
         if (in_valid && rdy1) idx++;
         @(negedge clk);
      end
      tests++; if (got.size() != 3) begin fails++; $display("FAIL bp_count: got %0d want 3", got.size()); end
      for (int k = 0; k < 3 && k < got.size(); k++) begin
         tests++; if (got[k] !== offers[k]) begin fails++; $display("FAIL bp_order[%0d]: got %h want %h", k, got[k], offers[k]); end
      end
      in_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_bubble;
      out_ready = 1'b1; in_valid = 1'b1; bubble = 1'b1; in_ctrl = 16'hFFFF; in_data = 32'h55;
      @(negedge clk);
      in_valid = 1'b0; bubble = 1'b0; in_ctrl = '0;
      #1;
      tests++; if (ov1 !== 1'b1 || oc1 !== NOP || od1 !== 32'h55) begin fails++; $display("FAIL bubble1: got v=%b c=%h d=%h want 1 %h 55", ov1, oc1, od1, NOP); end
      tests++; if (ov0 !== 1'b1 || oc0 !== NOP || od0 !== 32'h55) begin fails++; $display("FAIL bubble0: got v=%b c=%h d=%h want 1 %h 55", ov0, oc0, od0, NOP); end
      @(negedge clk);
      #1;
      tests++; if (ov1 !== 1'b0 || oc1 !== NOP || occ1 !== 2'd0) begin fails++; $display("FAIL bubble_drain: got v=%b c=%h occ=%0d want 0 %h 0", ov1, oc1, occ1, NOP); end
      @(negedge clk);
      bubble = 1'b1; in_valid = 1'b0; in_ctrl = 16'hFFFF; in_data = 32'h66;
      @(negedge clk);
      bubble = 1'b0;
      #1;
      tests++; if (ov1 !== 1'b0 || occ1 !== 2'd0 || oc1 !== NOP) begin fails++; $display("FAIL bubble_noinput: got v=%b occ=%0d c=%h want 0 0 %h", ov1, occ1, oc1, NOP); end
      @(negedge clk);
   endtask

   task automatic test_flush;
      out_ready = 1'b0; in_ctrl = 16'h0080;
      in_valid = 1'b1; in_data = 32'h11;
      @(negedge clk);
      in_data = 32'h22;
      @(negedge clk);
      #1;
      tests++; if (occ1 !== 2'd2) begin fails++; $display("FAIL flush_pre_occ: got %0d want 2", occ1); end
      flush = 1'b1; in_data = 32'h77;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      tests++; if (occ1 !== 2'd0 || ov1 !== 1'b0 || rdy1 !== 1'b1) begin fails++; $display("FAIL flush_state1: got occ=%0d v=%b r=%b want 0 0 1", occ1, ov1, rdy1); end
      tests++; if (occ0 !== 2'd0 || ov0 !== 1'b0) begin fails++; $display("FAIL flush_state0: got occ=%0d v=%b want 0 0", occ0, ov0); end
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         tests++; if (ov1 !== 1'b0 || ov0 !== 1'b0) begin fails++; $display("FAIL flush_ghost: got v=%b/%b d=%h want no output", ov1, ov0, od1); end
      end
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h33;
      @(negedge clk);
      flush = 1'b1; in_data = 32'h78;
      #1;
      tests++; if (rdy1 !== 1'b1) begin fails++; $display("FAIL flush_one_ready: got %b want 1", rdy1); end
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      tests++; if (occ1 !== 2'd0 || ov1 !== 1'b0) begin fails++; $display("FAIL flush_drop_in: got occ=%0d v=%b d=%h want 0 0", occ1, ov1, od1); end
      @(negedge clk);
   endtask

   task automatic test_random;
      logic [DW+CW-1:0] exp;
      q1.delete(); q0.delete();
      for (int c = 0; c < 10000; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 31) == 0);
         bubble    = ($urandom_range(0, 9) == 0);
         in_data   = $urandom;
         in_ctrl   = 16'($urandom);
         #1;
         tests++; if (occ1 !== 2'(q1.size())) begin fails++; $display("FAIL rnd_occ1 cyc %0d: got %0d want %0d", c, occ1, q1.size()); end
         tests++; if (rdy1 !== (q1.size() != 2)) begin fails++; $display("FAIL rnd_ready1 cyc %0d: got %b want %b", c, rdy1, q1.size() != 2); end
         tests++; if (occ0 !== 2'(q0.size())) begin fails++; $display("FAIL rnd_occ0 cyc %0d: got %0d want %0d", c, occ0, q0.size()); end
         tests++; if (rdy0 !== (q0.size() == 0 || out_ready)) begin fails++; $display("FAIL rnd_ready0 cyc %0d: got %b", c, rdy0); end
         if (!ov1) begin
            tests++; if (oc1 !== NOP) begin fails++; $display("FAIL rnd_idle_ctrl1 cyc %0d: got %h want %h", c, oc1, NOP); end
         end
         if (ov1 && out_ready) begin
            tests++;
            if (q1.size() == 0) begin fails++; $display("FAIL rnd_extra1 cyc %0d: got %h want none", c, {oc1, od1}); end
            else begin
               exp = q1.pop_front();
               if ({oc1, od1} !== exp) begin fails++; $display("FAIL rnd_data1 cyc %0d: got %h want %h", c, {oc1, od1}, exp); end
            end
         end
         if (ov0 && out_ready) begin
            tests++;
            if (q0.size() == 0) begin fails++; $display("FAIL rnd_extra0 cyc %0d: got %h want none", c, {oc0, od0}); end
            else begin
               exp = q0.pop_front();
               if ({oc0, od0} !== exp) begin fails++; $display("FAIL rnd_data0 cyc %0d: got %h want %h", c, {oc0, od0}, exp); end
            end
         end
         if (flush) begin
            q1.delete(); q0.delete();
         end else begin
            if (in_valid && rdy1) q1.push_back({bubble ? NOP : in_ctrl, in_data});
            if (in_valid && rdy0) q0.push_back({bubble ? NOP : in_ctrl, in_data});
         end
         @(negedge clk);
      end
      in_valid = 1'b0; flush = 1'b0; bubble = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; bubble = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_ctrl = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      test_reset;
      test_streaming;
      test_backpressure;
      test_bubble;
      test_flush;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
